// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchroniser, per-channel debounce counter,
// active-high debounced level plus one-cycle press/release strobes.
module button_conditioner #(
    parameter int unsigned N_BUTTONS     = 2,
    parameter int unsigned STABLE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] in_n,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

    logic [N_BUTTONS-1:0] sync1_q, sync1_d;
    logic [N_BUTTONS-1:0] sync2_q, sync2_d;
    logic [N_BUTTONS-1:0] pressed_q, pressed_d;
    logic [N_BUTTONS-1:0] press_pulse_q, press_pulse_d;
    logic [N_BUTTONS-1:0] release_pulse_q, release_pulse_d;
    logic [CntW-1:0]      cnt_q [N_BUTTONS];
    logic [CntW-1:0]      cnt_d [N_BUTTONS];
    logic [N_BUTTONS-1:0] btn_level;

    // Active-high view of the synchronised pins; the raw pins go no further.
    assign btn_level = ~sync2_q;

    always_comb begin
        sync1_d         = in_n;
        sync2_d         = sync1_q;
        pressed_d       = pressed_q;
        press_pulse_d   = '0;
        release_pulse_d = '0;
        cnt_d           = cnt_q;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (btn_level[i] == pressed_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                pressed_d[i]       = btn_level[i];
                press_pulse_d[i]   = btn_level[i];
                release_pulse_d[i] = ~btn_level[i];
                cnt_d[i]           = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q         <= '1;
            sync2_q         <= '1;
            pressed_q       <= '0;
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            cnt_q           <= '{default: '0};
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            cnt_q           <= cnt_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations,
// then random bouncy stimulus checked every cycle against a history-window model.
module tb_button_conditioner;

    localparam int unsigned NB = 2;
    localparam int unsigned SC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] in_n = '0;
    logic [NB-1:0] pressed, press_pulse, release_pulse;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .N_BUTTONS    (NB),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_n         (in_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pins reach the logic two edges late; a level is accepted once the
    // last SC observed levels all disagree with the current accepted level.
    bit [NB-1:0] m_s1, m_s2, m_pressed, m_pp, m_rp, m_lvl;
    bit          m_valid = 1'b0;
    bit          m_all;
    bit          hist0[$];
    bit          hist1[$];

    function automatic bit window_flips(input bit h[$], input bit cur);
        if (h.size() != SC) return 1'b0;
        foreach (h[k]) if (h[k] == cur) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '1;
            m_s2 = '1;
            hist0.delete();
            hist1.delete();
            m_pressed = '0;
            m_pp = '0;
            m_rp = '0;
            m_valid = 1'b1;
        end else begin
            m_lvl = ~m_s2;
            m_pp = '0;
            m_rp = '0;
            hist0.push_back(m_lvl[0]);
            hist1.push_back(m_lvl[1]);
            if (hist0.size() > SC) void'(hist0.pop_front());
            if (hist1.size() > SC) void'(hist1.pop_front());
            m_all = window_flips(hist0, m_pressed[0]);
            if (m_all) begin
                m_pressed[0] = m_lvl[0];
                m_pp[0] = m_lvl[0];
                m_rp[0] = ~m_lvl[0];
                hist0.delete();
            end
            m_all = window_flips(hist1, m_pressed[1]);
            if (m_all) begin
                m_pressed[1] = m_lvl[1];
                m_pp[1] = m_lvl[1];
                m_rp[1] = ~m_lvl[1];
                hist1.delete();
            end
            m_s2 = m_s1;
            m_s1 = in_n;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pressed", pressed, m_pressed);
            check("model_press_pulse", press_pulse, m_pp);
            check("model_release_pulse", release_pulse, m_rp);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int unsigned run [NB];
    logic [NB-1:0] cur;

    initial begin
        // Reset with both pins low (buttons held through reset)
        rst = 1'b1;
        in_n = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_pressed", pressed, 2'b00);
            check("rst_pulses", press_pulse | release_pulse, 2'b00);
        end
        rst = 1'b0;
        step(5);
        check("t1_before_edge6", pressed, 2'b00);
        step(1);
        check("t1_edge6_pressed", pressed, 2'b11);
        check("t1_edge6_pulse", press_pulse, 2'b11);
        step(1);
        check("t1_pulse_drop", press_pulse, 2'b00);

        in_n = 2'b11;
        step(8);
        check("t1_released", pressed, 2'b00);

        // Clean press on channel 0
        in_n = 2'b10;
        step(5);
        check("t2_before_e5", pressed, 2'b00);
        step(1);
        check("t2_e5_pressed", pressed, 2'b01);
        check("t2_e5_pulse", press_pulse, 2'b01);
        step(1);
        check("t2_pulse_drop", press_pulse, 2'b00);
        check("t2_pressed_held", pressed, 2'b01);

        // Release on channel 0
        in_n = 2'b11;
        step(5);
        check("t4_before_e5", pressed, 2'b01);
        step(1);
        check("t4_e5_pressed", pressed, 2'b00);
        check("t4_e5_rel_pulse", release_pulse, 2'b01);
        check("t4_no_press_pulse", press_pulse, 2'b00);
        step(1);
        check("t4_rel_drop", release_pulse, 2'b00);

        // Bounce shorter than the stable window
        for (int i = 0; i < 8; i++) begin
            in_n = {1'b1, (i % 2) == 1};
            step(1);
            check("t3_pressed", pressed, 2'b00);
            check("t3_pulses", press_pulse | release_pulse, 2'b00);
        end
        in_n = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t3_settle", pressed | press_pulse | release_pulse, 2'b00);
        end

        // Reset in the middle of a count on channel 1
        in_n = 2'b01;
        step(3);
        rst = 1'b1;
        step(1);
        check("t5_in_reset", pressed, 2'b00);
        rst = 1'b0;
        step(5);
        check("t5_before_e5", pressed, 2'b00);
        step(1);
        check("t5_e5_pressed", pressed, 2'b10);
        check("t5_e5_pulse", press_pulse, 2'b10);
        in_n = 2'b11;
        step(10);
        check("t5_released", pressed, 2'b00);

        // Concurrent press
        in_n = 2'b00;
        step(5);
        check("t6_before_e5", pressed, 2'b00);
        step(1);
        check("t6_e5_pressed", pressed, 2'b11);
        check("t6_e5_pulse", press_pulse, 2'b11);
        step(1);
        check("t6_pulse_drop", press_pulse, 2'b00);
        in_n = 2'b11;
        step(10);

        // Random bouncy stimulus with occasional resets
        cur = 2'b11;
        run[0] = 0;
        run[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (run[i] == 0) begin
                    cur[i] = 1'($urandom_range(0, 1));
                    run[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 12)
                                                         : $urandom_range(1, 5);
                end
                run[i]--;
            end
            in_n = cur;
            rst = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
